// File: rtl/spi_frame_master.sv
// SPI frame master: turns {op, byte} commands into 10-bit SPI frames with a leading CHK slot,
// and for read-data frames waits out the RAM turnaround before capturing 8 MISO bits.
module spi_frame_master #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_byte,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_SHIFT,
        S_WAIT,
        S_READ,
        S_END
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, cnt_dec;
    logic [9:0] frame, frame_n;
    logic [7:0] sh, sh_n;
    logic [7:0] rsp_data_n;
    logic       rsp_valid_n;
    logic       mosi_n;

    assign cnt_dec = cnt - 4'd1;

    // Outputs are computed for the state being entered, so the registered pins line up with it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        frame_n     = frame;
        sh_n        = sh;
        rsp_data_n  = rsp_data;
        rsp_valid_n = 1'b0;
        mosi_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    frame_n = {cmd_op, cmd_byte};
                    state_n = S_CHK;
                    mosi_n  = cmd_op[1];
                end
            end
            S_CHK: begin
                state_n = S_SHIFT;
                cnt_n   = 4'd9;
                mosi_n  = frame[9];
            end
            S_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (frame[9:8] == 2'b11) begin
                        if (RD_WAIT == 0) begin
                            state_n = S_READ;
                            cnt_n   = 4'd7;
                        end else begin
                            state_n = S_WAIT;
                            cnt_n   = WAIT_LOAD;
                        end
                    end else begin
                        state_n = S_END;
                        cnt_n   = GAP_LOAD;
                    end
                end else begin
                    cnt_n  = cnt_dec;
                    mosi_n = frame[cnt_dec];
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = S_READ;
                    cnt_n   = 4'd7;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            S_READ: begin
                sh_n = {sh[6:0], MISO};
                if (cnt == 4'd0) begin
                    state_n     = S_END;
                    cnt_n       = GAP_LOAD;
                    rsp_data_n  = {sh[6:0], MISO};
                    rsp_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            S_END: begin
                if (cnt == 4'd0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            frame     <= 10'd0;
            sh        <= 8'h00;
            rsp_data  <= 8'h00;
            rsp_valid <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame     <= frame_n;
            sh        <= sh_n;
            rsp_data  <= rsp_data_n;
            rsp_valid <= rsp_valid_n;
            SS_n      <= (state_n == S_IDLE) || (state_n == S_END);
            MOSI      <= mosi_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: two instances (default timing and RD_WAIT=0/GAP=3) checked cycle by
// cycle against a frame-level model of SS_n, MOSI, handshake and response behaviour.
module tb_spi_frame_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd_valid_w, cmd_ready_w, rsp_valid_w, busy_w, ss_n_w, mosi_w, miso_w;
    logic [1:0] cmd_op;
    logic [7:0] cmd_byte;
    logic [7:0] rsp_data_w [2];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] last_rsp [2];
    int         rwp [2] = '{2, 0};
    int         gpp [2] = '{1, 3};

    always #5 clk = ~clk;

    spi_frame_master dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
        .busy(busy_w[0]), .SS_n(ss_n_w[0]), .MOSI(mosi_w[0]), .MISO(miso_w[0])
    );

    spi_frame_master #(.RD_WAIT(0), .GAP(3)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
        .busy(busy_w[1]), .SS_n(ss_n_w[1]), .MOSI(mosi_w[1]), .MISO(miso_w[1])
    );

    // One full command on instance sel; mode 0 = single pulse, 1 = cmd_valid held, 2 = random cmd noise.
    task automatic run_frame(input int sel, input logic [1:0] op, input logic [7:0] data,
                             input logic [7:0] mb, input int mode);
        int         rw, gp, low, idx;
        logic       exp_mosi;
        logic [9:0] fr;
        rw  = rwp[sel];
        gp  = gpp[sel];
        low = 11 + ((op == 2'b11) ? rw + 8 : 0);
        fr  = {op, data};
        cmd_op = op;
        cmd_byte = data;
        cmd_valid_w[sel] = 1'b1;
        n_checks++;
        if (cmd_ready_w[sel] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_before dut%0d: got %b want 1", sel, cmd_ready_w[sel]);
        end
        @(posedge clk); #1;
        cmd_valid_w[sel] = (mode == 1);
        cmd_op = 2'($urandom);
        cmd_byte = 8'($urandom);
        for (int j = 0; j < low; j++) begin
            exp_mosi = (j == 0) ? fr[9] : (j <= 10) ? fr[10 - j] : 1'b0;
            n_checks++;
            if (ss_n_w[sel] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ss_n_low dut%0d cyc %0d: got %b want 0", sel, j, ss_n_w[sel]);
            end
            n_checks++;
            if (mosi_w[sel] !== exp_mosi) begin
                n_fail++;
                $display("[TB] FAIL mosi dut%0d op %0d cyc %0d: got %b want %b", sel, op, j, mosi_w[sel], exp_mosi);
            end
            n_checks++;
            if (busy_w[sel] !== 1'b1 || cmd_ready_w[sel] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL busy_ready dut%0d cyc %0d: got busy %b ready %b want 1/0", sel, j, busy_w[sel], cmd_ready_w[sel]);
            end
            n_checks++;
            if (rsp_valid_w[sel] !== 1'b0 || rsp_data_w[sel] !== last_rsp[sel]) begin
                n_fail++;
                $display("[TB] FAIL rsp_during dut%0d cyc %0d: got %b/%h want 0/%h", sel, j, rsp_valid_w[sel], rsp_data_w[sel], last_rsp[sel]);
            end
            idx = j - 11 - rw;
            if (op == 2'b11 && idx >= 0) miso_w[sel] = mb[7 - idx];
            else                          miso_w[sel] = 1'($urandom);
            if (mode == 2) begin
                cmd_valid_w[sel] = 1'($urandom);
                cmd_op = 2'($urandom);
                cmd_byte = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        if (op == 2'b11) last_rsp[sel] = mb;
        for (int g = 0; g < gp; g++) begin
            n_checks++;
            if (ss_n_w[sel] !== 1'b1 || mosi_w[sel] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL gap_pins dut%0d gap %0d: got ss_n %b mosi %b want 1/0", sel, g, ss_n_w[sel], mosi_w[sel]);
            end
            n_checks++;
            if (busy_w[sel] !== 1'b1 || cmd_ready_w[sel] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL gap_busy dut%0d gap %0d: got busy %b ready %b want 1/0", sel, g, busy_w[sel], cmd_ready_w[sel]);
            end
            n_checks++;
            if (rsp_valid_w[sel] !== (op == 2'b11 && g == 0)) begin
                n_fail++;
                $display("[TB] FAIL rsp_valid dut%0d gap %0d: got %b want %b", sel, g, rsp_valid_w[sel], (op == 2'b11 && g == 0));
            end
            n_checks++;
            if (rsp_data_w[sel] !== last_rsp[sel]) begin
                n_fail++;
                $display("[TB] FAIL rsp_data dut%0d gap %0d: got %h want %h", sel, g, rsp_data_w[sel], last_rsp[sel]);
            end
            miso_w[sel] = 1'($urandom);
            if (mode == 2) begin
                cmd_valid_w[sel] = 1'($urandom);
                cmd_op = 2'($urandom);
                cmd_byte = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (cmd_ready_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || ss_n_w[sel] !== 1'b1 || rsp_valid_w[sel] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after dut%0d: got ready %b busy %b ss_n %b rsp_valid %b want 1/0/1/0",
                     sel, cmd_ready_w[sel], busy_w[sel], ss_n_w[sel], rsp_valid_w[sel]);
        end
        if (mode != 1) cmd_valid_w[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (ss_n_w[s] !== 1'b1 || mosi_w[s] !== 1'b0 || cmd_ready_w[s] !== 1'b1 || busy_w[s] !== 1'b0 ||
                rsp_valid_w[s] !== 1'b0 || rsp_data_w[s] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset dut%0d: got ss_n %b mosi %b ready %b busy %b rv %b rd %h want 1 0 1 0 0 00",
                         s, ss_n_w[s], mosi_w[s], cmd_ready_w[s], busy_w[s], rsp_valid_w[s], rsp_data_w[s]);
            end
        end
        last_rsp[0] = 8'h00;
        last_rsp[1] = 8'h00;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_addr();
        run_frame(0, 2'b00, 8'hCC, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 2'b01, 8'hCC, 8'h00, 1);
        run_frame(0, 2'b10, 8'hCC, 8'h00, 0);
    endtask

    task automatic test_read_data();
        run_frame(0, 2'b11, 8'h3C, 8'hA5, 0);
        run_frame(0, 2'b00, 8'h12, 8'h00, 0);
        run_frame(1, 2'b11, 8'h00, 8'hA5, 0);
    endtask

    task automatic test_ignore_busy();
        run_frame(0, 2'b00, 8'h5A, 8'h00, 2);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (ss_n_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL no_extra_frame cyc %0d: got ss_n %b busy %b want 1/0", k, ss_n_w[0], busy_w[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_read();
        cmd_op = 2'b11;
        cmd_byte = 8'h00;
        cmd_valid_w[0] = 1'b1;
        @(posedge clk); #1;
        cmd_valid_w[0] = 1'b0;
        for (int j = 0; j < 16; j++) begin
            miso_w[0] = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        last_rsp[0] = 8'h00;
        last_rsp[1] = 8'h00;
        n_checks++;
        if (ss_n_w[0] !== 1'b1 || mosi_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || cmd_ready_w[0] !== 1'b1 ||
            rsp_valid_w[0] !== 1'b0 || rsp_data_w[0] !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_read_reset: got ss_n %b mosi %b busy %b ready %b rv %b rd %h want 1 0 0 1 0 00",
                     ss_n_w[0], mosi_w[0], busy_w[0], cmd_ready_w[0], rsp_valid_w[0], rsp_data_w[0]);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid_w[0] !== 1'b0 || ss_n_w[0] !== 1'b1 || rsp_data_w[0] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL after_abort cyc %0d: got rv %b ss_n %b rd %h want 0 1 00", k, rsp_valid_w[0], ss_n_w[0], rsp_data_w[0]);
            end
        end
    endtask

    task automatic test_random();
        int sel, mode, idle;
        for (int n = 0; n < 24; n++) begin
            sel  = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            idle = int'($urandom_range(0, 2));
            if (idle > 0) begin
                cmd_valid_w = 2'b00;
                repeat (idle) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (ss_n_w !== 2'b11 || busy_w !== 2'b00) begin
                        n_fail++;
                        $display("[TB] FAIL rand_idle: got ss_n %b busy %b want 11/00", ss_n_w, busy_w);
                    end
                end
            end
            cmd_valid_w[1 - sel] = 1'b0;
            run_frame(sel, 2'($urandom), 8'($urandom), 8'($urandom), mode);
        end
        cmd_valid_w = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_w = 2'b00;
        miso_w = 2'b00;
        cmd_op = 2'b00;
        cmd_byte = 8'h00;
        #1;
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_read_data();
        test_ignore_busy();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
